quad_odo_hub: RTL
=================

QUAD_ODO_HUB -- requirements
Module: quad_odo_hub

Interface
REQ-001 The module SHALL have parameter N_CH, default 4, meaning the number of quadrature channels (1..16).
REQ-002 The module SHALL have parameter CNT_W, default 32, meaning the count and speed width (16..32).
REQ-003 The module SHALL have parameter WINDOW_CYC, default 500_000, meaning the speed window in clocks (10 ms at 50 MHz).
REQ-004 The module SHALL have parameter FILT_LEN, default 3, meaning the number of consecutive stable cycles for the glitch filter (1..15).
REQ-005 The module SHALL have port CLOCK_50, input, 1 bit, the clock; all logic is on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-007 The module SHALL have ports quad_a and quad_b, inputs, N_CH bits each, asynchronous encoder phases.
REQ-008 The module SHALL have port clr_req, input, 1 bit, a clear strobe.
REQ-009 The module SHALL have port clr_mask, input, N_CH bits, selecting the channels cleared by clr_req.
REQ-010 The module SHALL have port snap_req, input, 1 bit, a snapshot request strobe.
REQ-011 The module SHALL have port snap_ack, output, 1 bit, a pulse marking shadow registers updated.
REQ-012 The module SHALL have port rd_addr, input, 8 bits, the read address into the shadow map.
REQ-013 The module SHALL have port rd_data, output, 32 bits, read data, combinational from rd_addr.
REQ-014 The module SHALL have port speed_valid, output, 1 bit, a pulse at each window end.
REQ-015 The module SHALL have port err_flags, output, N_CH bits, live sticky illegal-transition flags.

Function
REQ-016 Each phase SHALL pass through a 2-FF synchroniser, then a filter that adopts a new level only after FILT_LEN consecutive equal synchronised samples.
REQ-017 Decoding SHALL be 4x Gray: sequence 00->01->11->10->00 increments the count, the reverse sequence decrements it, and no change holds the count.
REQ-018 A filtered A/B change where both phases flip in one cycle SHALL leave the count unchanged and set err_flags[i], which is sticky.
REQ-019 A count SHALL be two's complement CNT_W bits; it wraps modulo 2^CNT_W (max+1 -> min, min-1 -> max) with no saturation.
REQ-020 Latency SHALL be exactly FILT_LEN+3 clocks from a pin change (stable before a clock edge) to the updated count.
REQ-021 The window counter SHALL count 0..WINDOW_CYC-1 and wrap.
REQ-022 At the terminal value of the window counter, each channel SHALL compute speed[i] <= count[i] - prev[i] (mod 2^CNT_W, signed), load prev[i] <= count[i], and pulse speed_valid for exactly 1 cycle.
REQ-023 On clr_req, for each i with clr_mask[i]=1, count[i], prev[i], speed[i] and err_flags[i] SHALL be set to 0 on the next edge.
REQ-024 A clear SHALL take priority over a simultaneous decode step and over a simultaneous speed update for that channel.
REQ-025 On snap_req, the shadow registers SHALL capture the count, speed and err values present in the request cycle, pre-update, on the next edge.
REQ-026 snap_ack SHALL pulse 1 cycle, in the cycle after capture, i.e. 2 edges after snap_req is sampled.
REQ-027 snap_req asserted while a capture is pending SHALL be merged into that capture, with a single snap_ack.
REQ-028 The shadow registers SHALL be stable between snapshots; rd_data SHALL never read live counters.
REQ-029 The address map SHALL be: 0..N_CH-1 shadow counts; N_CH..2N_CH-1 shadow speeds; 2N_CH shadow err word (zero-extended); 2N_CH+1 ID constant 0x0DE0_0D0B; other addresses 0xFFFF_FFFF.
REQ-030 Values narrower than 32 bits SHALL be sign-extended on rd_data.

Reset
REQ-031 On reset, all counts, prev, speeds, shadows, err_flags, filters and the window counter SHALL be 0, with synchroniser and filter states at 0.
REQ-032 On reset, snap_ack and speed_valid SHALL be 0.
REQ-033 Reset SHALL abort a pending snapshot with no snap_ack, and restart the window at 0.
REQ-034 The first post-reset speed_valid SHALL occur WINDOW_CYC clocks after reset deasserts.

Structure
REQ-035 Package odo_pkg SHALL hold the address-offset helper functions, the ID constant, the default-read constant and the quadrature state typedef (2-bit enum).
REQ-036 Sub-module quad_chan SHALL contain sync, filter, decode, count, prev, speed and err for one channel, and be instantiated N_CH times by generate.
REQ-037 Window counter, snapshot logic and read mux SHALL be in quad_odo_hub.

Verification
REQ-038 With 4 rising-A-leading cycles (16 edges, 20 clocks each) on ch0 then snap_req, the bench SHALL require count0 = 16 at addr 0, count1..3 = 0, and snap_ack exactly 2 clocks after snap_req.
REQ-039 With reverse sequence from 0 for 1 step (CNT_W=16), the bench SHALL require addr 0 to read 0xFFFF_FFFF; with the count preset near 0x7FFF plus 1 step, it SHALL require 0xFFFF_8000.
REQ-040 With a 2-cycle glitch on A (FILT_LEN=3), the bench SHALL require no count change; with A and B flipping together, it SHALL require an unchanged count and err_flags[0]=1, and addr 2N_CH bit0 = 1 after snapshot.
REQ-041 With WINDOW_CYC=100 and 25 steps inside one window, the bench SHALL require speed_valid every 100 clocks and speed0 = 25 then 0 in the next idle window.
REQ-042 With clr_req, clr_mask=4'b0010 coinciding with a ch1 step and a window end, the bench SHALL require count1 = speed1 = err1 = 0 and other channels unaffected.
REQ-043 With reset asserted 1 cycle after snap_req, the bench SHALL require no snap_ack and all shadow reads = 0 except ID and unmapped addresses.

Source files
------------

// File: rtl/odo_pkg.sv
// Shared constants, quadrature state encoding and read-map helpers for the
// odometry hub and its channels.
package odo_pkg;

  localparam logic [31:0] ID_WORD    = 32'h0DE0_0D0B;
  localparam logic [31:0] RD_DEFAULT = 32'hFFFF_FFFF;

  // State bits are {b, a}; forward rotation is 00 -> 01 -> 11 -> 10 -> 00.
  typedef enum logic [1:0] {
    Q_00 = 2'b00,
    Q_01 = 2'b01,
    Q_11 = 2'b11,
    Q_10 = 2'b10
  } quad_state_t;

  // Gray-to-binary position on the forward rotation.
  function automatic logic [1:0] quad_pos(input quad_state_t s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  function automatic int speed_base(input int n_ch);
    return n_ch;
  endfunction

  function automatic int err_addr(input int n_ch);
    return 2 * n_ch;
  endfunction

  function automatic int id_addr(input int n_ch);
    return 2 * n_ch + 1;
  endfunction

endpackage

// File: rtl/quad_chan.sv
// One quadrature channel: 2-FF synchroniser, per-phase glitch filter, 4x Gray
// decoder, wrapping position count and windowed speed with sticky error.
//   state | meaning
//   Q_00  | A low,  B low
//   Q_01  | A high, B low
//   Q_11  | A high, B high
//   Q_10  | A low,  B high
module quad_chan
  import odo_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clr,
  input  logic             win_end,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] speed,
  output logic             err
);

  localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

  logic [1:0]       sync_a;
  logic [1:0]       sync_b;
  logic [1:0]       filt;
  logic [3:0]       run_a;
  logic [3:0]       run_b;
  quad_state_t      q_prev;
  quad_state_t      q_cur;
  logic [1:0]       step;
  logic [CNT_W-1:0] prev;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[0], quad_a};
      sync_b <= {sync_b[0], quad_b};
    end
  end

  // A new level is adopted on the FILT_LEN-th consecutive differing sample.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt  <= '0;
      run_a <= '0;
      run_b <= '0;
    end else begin
      if (sync_a[1] == filt[0]) begin
        run_a <= '0;
      end else if (run_a == RUN_LAST) begin
        filt[0] <= sync_a[1];
        run_a   <= '0;
      end else begin
        run_a <= run_a + 4'd1;
      end
      if (sync_b[1] == filt[1]) begin
        run_b <= '0;
      end else if (run_b == RUN_LAST) begin
        filt[1] <= sync_b[1];
        run_b   <= '0;
      end else begin
        run_b <= run_b + 4'd1;
      end
    end
  end

  assign q_cur = quad_state_t'(filt);
  assign step  = quad_pos(q_cur) - quad_pos(q_prev);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      q_prev <= Q_00;
      count  <= '0;
      prev   <= '0;
      speed  <= '0;
      err    <= 1'b0;
    end else begin
      q_prev <= q_cur;
      if (clr) begin
        count <= '0;
        prev  <= '0;
        speed <= '0;
        err   <= 1'b0;
      end else begin
        case (step)
          2'd1:    count <= count + CNT_W'(1);
          2'd3:    count <= count - CNT_W'(1);
          2'd2:    err   <= 1'b1;
          default: ;
        endcase
        // Speed uses the pre-step count, so a coincident step lands in the next window.
        if (win_end) begin
          speed <= count - prev;
          prev  <= count;
        end
      end
    end
  end

endmodule

// File: rtl/quad_odo_hub.sv
// Multi-channel quadrature odometry hub: per-channel decoders, shared speed
// window, snapshot shadow registers and a combinational read map.
module quad_odo_hub
  import odo_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int WINDOW_CYC = 500_000,
  parameter int FILT_LEN   = 3
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic [N_CH-1:0] quad_a,
  input  logic [N_CH-1:0] quad_b,
  input  logic            clr_req,
  input  logic [N_CH-1:0] clr_mask,
  input  logic            snap_req,
  output logic            snap_ack,
  input  logic [7:0]      rd_addr,
  output logic [31:0]     rd_data,
  output logic            speed_valid,
  output logic [N_CH-1:0] err_flags
);

  localparam int               WIN_W    = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);

  logic [WIN_W-1:0] win_cnt;
  logic             win_end;
  logic             snap_pend;
  logic [CNT_W-1:0] cnt_live [N_CH];
  logic [CNT_W-1:0] spd_live [N_CH];
  logic [N_CH-1:0]  err_live;
  logic [CNT_W-1:0] cnt_shd  [N_CH];
  logic [CNT_W-1:0] spd_shd  [N_CH];
  logic [N_CH-1:0]  err_shd;

  assign win_end = (win_cnt == WIN_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      win_cnt     <= '0;
      speed_valid <= 1'b0;
    end else begin
      speed_valid <= win_end;
      win_cnt     <= win_end ? '0 : win_cnt + WIN_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    quad_chan #(
      .CNT_W   (CNT_W),
      .FILT_LEN(FILT_LEN)
    ) u_chan (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .quad_a  (quad_a[i]),
      .quad_b  (quad_b[i]),
      .clr     (clr_req & clr_mask[i]),
      .win_end (win_end),
      .count   (cnt_live[i]),
      .speed   (spd_live[i]),
      .err     (err_live[i])
    );
  end

  assign err_flags = err_live;

  // A request arriving while a capture is pending folds into it (one ack).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      snap_pend <= 1'b0;
      snap_ack  <= 1'b0;
      cnt_shd   <= '{default: '0};
      spd_shd   <= '{default: '0};
      err_shd   <= '0;
    end else begin
      snap_ack <= snap_pend;
      if (snap_req && !snap_pend) begin
        snap_pend <= 1'b1;
        cnt_shd   <= cnt_live;
        spd_shd   <= spd_live;
        err_shd   <= err_live;
      end else begin
        snap_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = RD_DEFAULT;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(rd_addr) == i)                    rd_data = 32'(signed'(cnt_shd[i]));
      if (int'(rd_addr) == speed_base(N_CH) + i) rd_data = 32'(signed'(spd_shd[i]));
    end
    if (int'(rd_addr) == err_addr(N_CH)) rd_data = 32'(err_shd);
    if (int'(rd_addr) == id_addr(N_CH))  rd_data = ID_WORD;
  end

endmodule
